// File: rtl/fir_block_averager.sv
// Block averager after the FIR stage: sums 2^LOG2M valid samples and pushes the rounded mean
// into a small first-word-fall-through FIFO drained through a valid/ready handshake.
module fir_block_averager #(
    parameter int N     = 7,
    parameter int LOG2M = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [N:0]                 x_in,
    input  logic                       m_ready,
    input  logic                       clr_ovf,
    output logic                       m_valid,
    output logic [N:0]                 m_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow
);

    localparam int AW = N + 1 + LOG2M;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LOG2M-1:0] CNT_LAST = LOG2M'((1 << LOG2M) - 1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

    logic [LOG2M-1:0] r_cnt;
    logic [AW-1:0]    r_acc;
    logic [N:0]       r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;

    logic [AW-1:0] w_base;
    logic [AW-1:0] w_sum;
    logic [N:0]    w_avg;
    logic          w_last;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;

    // The first sample of a group starts from zero, so one adder serves every phase.
    assign w_base = (r_cnt == '0) ? '0 : r_acc;
    assign w_sum  = w_base + AW'(x_in);
    // Round half up: floor(sum/M) plus one when the dropped fraction is at least one half.
    assign w_avg  = w_sum[AW-1:LOG2M] + (N+1)'(w_sum[LOG2M-1]);

    assign w_last = in_valid && (r_cnt == CNT_LAST);
    assign w_pop  = (r_level != '0) && m_ready;
    assign w_full = (r_level == LVL_FULL);
    assign w_push = w_last && (!w_full || w_pop);
    assign w_drop = w_last && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (in_valid) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_sum;
        end
    end

    // NOTE: the FIFO storage has no reset; occupancy lives in the pointers and level, and m_data is gated while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_avg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign m_valid    = (r_level != '0);
    assign m_data     = m_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fir_block_averager.sv
// Directed bench for fir_block_averager: inputs change and outputs are sampled 1 ns after
// each rising edge, against hand-computed averages.
module tb_fir_block_averager;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] x_in;
    logic       m_ready;
    logic       clr_ovf;
    logic       m_valid;
    logic [7:0] m_data;
    logic [2:0] fifo_level;
    logic       overflow;

    int test_count = 0;
    int fail_count = 0;

    fir_block_averager #(.N(7), .LOG2M(2), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .x_in       (x_in),
        .m_ready    (m_ready),
        .clr_ovf    (clr_ovf),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x);
        in_valid = 1'b1;
        x_in     = x;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; x_in = '0; m_ready = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        test_count++;
        if (m_valid !== 1'b0) begin fail_count++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        test_count++;
        if (m_data !== 8'd0) begin fail_count++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        test_count++;
        if (fifo_level !== 3'd0) begin fail_count++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        test_count++;
        if (overflow !== 1'b0) begin fail_count++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        send(8'd10); send(8'd20); send(8'd30);
        test_count++;
        if (m_valid !== 1'b0) begin fail_count++; $display("FAIL basic_early_valid got %0b want 0", m_valid); end
        send(8'd40);
        test_count++;
        if (m_valid !== 1'b1 || m_data !== 8'd25) begin
            fail_count++; $display("FAIL basic_out got valid=%0b data=%0d want valid=1 data=25", m_valid, m_data);
        end
        test_count++;
        if (fifo_level !== 3'd1) begin fail_count++; $display("FAIL basic_level1 got %0d want 1", fifo_level); end
        idle();
        test_count++;
        if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin
            fail_count++; $display("FAIL basic_drain got valid=%0b level=%0d want 0/0", m_valid, fifo_level);
        end
    endtask

    task automatic test_rounding();
        logic [7:0] grp [4][4];
        logic [7:0] exp_avg [4];
        grp[0] = '{8'd1, 8'd1, 8'd1, 8'd2};       exp_avg[0] = 8'd1;
        grp[1] = '{8'd1, 8'd2, 8'd2, 8'd2};       exp_avg[1] = 8'd2;
        grp[2] = '{8'd255, 8'd255, 8'd255, 8'd255}; exp_avg[2] = 8'd255;
        grp[3] = '{8'd0, 8'd0, 8'd0, 8'd1};       exp_avg[3] = 8'd0;
        m_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int s = 0; s < 4; s++) send(grp[g][s]);
            test_count++;
            if (m_valid !== 1'b1 || m_data !== exp_avg[g]) begin
                fail_count++;
                $display("FAIL round_grp%0d got valid=%0b data=%0d want valid=1 data=%0d", g, m_valid, m_data, exp_avg[g]);
            end
            idle();
        end
    endtask

    task automatic test_gapped();
        m_ready = 1'b1;
        send(8'd8); idle(); send(8'd8); idle(); send(8'd8); idle();
        test_count++;
        if (m_valid !== 1'b0) begin fail_count++; $display("FAIL gap_early_valid got %0b want 0", m_valid); end
        send(8'd8);
        test_count++;
        if (m_valid !== 1'b1 || m_data !== 8'd8) begin
            fail_count++; $display("FAIL gap_out got valid=%0b data=%0d want valid=1 data=8", m_valid, m_data);
        end
        idle();
        test_count++;
        if (m_valid !== 1'b0) begin fail_count++; $display("FAIL gap_single got %0b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            for (int s = 0; s < 4; s++) send(8'(k));
        end
        test_count++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            fail_count++; $display("FAIL bp_full got level=%0d ovf=%0b want 4/0", fifo_level, overflow);
        end
        send(8'd5); send(8'd5); send(8'd5);
        // The dropping edge also carries a clear; the drop must win.
        clr_ovf = 1'b1;
        send(8'd5);
        clr_ovf = 1'b0;
        test_count++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            fail_count++; $display("FAIL bp_drop got level=%0d ovf=%0b want 4/1", fifo_level, overflow);
        end
        m_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            test_count++;
            if (m_valid !== 1'b1 || m_data !== 8'(k)) begin
                fail_count++; $display("FAIL bp_order%0d got valid=%0b data=%0d want valid=1 data=%0d", k, m_valid, m_data, k);
            end
            idle();
        end
        test_count++;
        if (fifo_level !== 3'd0 || m_valid !== 1'b0 || overflow !== 1'b1) begin
            fail_count++; $display("FAIL bp_empty got level=%0d valid=%0b ovf=%0b want 0/0/1", fifo_level, m_valid, overflow);
        end
        clr_ovf = 1'b1;
        idle();
        clr_ovf = 1'b0;
        test_count++;
        if (overflow !== 1'b0) begin fail_count++; $display("FAIL bp_clear got %0b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            for (int s = 0; s < 4; s++) send(8'(10 * k));
        end
        send(8'd50); send(8'd50); send(8'd50);
        m_ready = 1'b1;
        send(8'd50);
        test_count++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || m_data !== 8'd20) begin
            fail_count++;
            $display("FAIL b2b_full got level=%0d ovf=%0b head=%0d want 4/0/20", fifo_level, overflow, m_data);
        end
        for (int k = 2; k <= 5; k++) begin
            test_count++;
            if (m_valid !== 1'b1 || m_data !== 8'(10 * k)) begin
                fail_count++; $display("FAIL b2b_order%0d got valid=%0b data=%0d want valid=1 data=%0d", k, m_valid, m_data, 10 * k);
            end
            idle();
        end
        test_count++;
        if (fifo_level !== 3'd0) begin fail_count++; $display("FAIL b2b_empty got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_mid_group();
        m_ready = 1'b1;
        send(8'd100); send(8'd100);
        rst = 1'b0;
        idle();
        rst = 1'b1;
        test_count++;
        if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin
            fail_count++; $display("FAIL rstmid_state got valid=%0b level=%0d want 0/0", m_valid, fifo_level);
        end
        send(8'd4); send(8'd4); send(8'd4);
        test_count++;
        if (m_valid !== 1'b0) begin fail_count++; $display("FAIL rstmid_early got %0b want 0", m_valid); end
        send(8'd4);
        test_count++;
        if (m_valid !== 1'b1 || m_data !== 8'd4 || fifo_level !== 3'd1) begin
            fail_count++;
            $display("FAIL rstmid_out got valid=%0b data=%0d level=%0d want 1/4/1", m_valid, m_data, fifo_level);
        end
        idle();
        test_count++;
        if (m_valid !== 1'b0) begin fail_count++; $display("FAIL rstmid_single got %0b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_gapped();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_group();
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/fir_block_averager.md
Name: fir_block_averager

Overview:
- Downstream consumer of the 4-tap shift-add FIR stage.
- Takes one filtered sample per valid cycle and accumulates M = 2^LOG2M consecutive samples.
- Emits their rounded mean as one decimated sample.
- Decimated samples are buffered in a small first-word-fall-through (FWFT) FIFO with a valid/ready output handshake, so the downstream sink can stall without stalling the free-running filter.

Parameters:
- N, 7, MSB index of sample width (samples are N+1 bits, unsigned).
- LOG2M, 2, log2 of decimation factor M (M = 4 by default); legal range 1..4.
- DEPTH, 4, output FIFO depth in entries; power of two, at least 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  x_in carries a new filtered sample this cycle.
- x_in  input  N+1  filtered sample from the FIR stage, unsigned.
- m_ready  input  1  downstream accepts m_data this cycle.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- m_valid  output  1  FIFO non-empty; m_data is valid.
- m_data  output  N+1  head-of-FIFO decimated sample.
- fifo_level  output  $clog2(DEPTH+1)  number of occupied FIFO entries.
- overflow  output  1  sticky: a decimated sample was dropped because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous) sets the following to 0: phase counter, accumulator, FIFO pointers, fifo_level, m_valid, overflow. m_data reads 0 while empty after reset. Reset mid-group discards the partial sum.
- Phase counter cnt runs 0..M-1 and advances only on cycles where in_valid=1. It wraps from M-1 to 0. Cycles with in_valid=0 hold all accumulator state.
- Accumulator is N+1+LOG2M bits wide and never overflows:
  - in_valid and cnt==0: acc <= x_in.
  - in_valid and 0<cnt<M-1: acc <= acc + x_in.
  - in_valid and cnt==M-1: compute sum = acc + x_in, then avg = (sum + M/2) >> LOG2M (round half up). avg always fits in N+1 bits; no saturation is needed.
- At cnt==M-1, avg is a push request to the FIFO in the same edge.
- Push rules:
  - FIFO not full: write avg, level+1.
  - FIFO full and (m_valid and m_ready) in the same cycle: the pop and push both occur; level stays at DEPTH and no drop occurs.
  - FIFO full with no pop: avg is discarded, overflow <= 1, and FIFO contents are unchanged.
- Pop rule: a pop occurs when m_valid and m_ready are both 1. The head advances on that edge. m_ready while empty has no effect.
- Simultaneous push and pop with a non-empty FIFO leaves the level unchanged.
- FWFT: m_valid = (level != 0), and m_data = entry at the read pointer, combinational from registered state.
- Latency: the edge that accepts the M-th sample of a group, with the FIFO empty, makes m_valid=1 with the result on m_data directly after that edge (1 cycle).
- Pointers are LOG2(DEPTH) bits and wrap naturally. level is tracked in a separate counter.
- overflow is sticky until clr_ovf=1. If clr_ovf and a drop occur in the same cycle, the set wins (overflow stays 1).
- m_data and the ordering of accepted samples are strictly FIFO; no reordering or duplication.

Test Plan:
- Reset, then in_valid=1 with x_in 10,20,30,40 on consecutive cycles and m_ready=1 → one output: m_valid=1 for 1 cycle with m_data=25 ((100+2)>>2); fifo_level returns to 0.
- Rounding: group 1,1,1,2 → m_data=1; group 1,2,2,2 → m_data=2; group 255,255,255,255 → m_data=255; group 0,0,0,1 → m_data=0.
- Gapped input: samples 8,8,8,8 with in_valid toggling 1/0 every cycle → exactly one output, m_data=8, produced on the edge after the 4th valid sample; idle cycles leave acc unchanged.
- Backpressure: m_ready=0, five groups with averages 1,2,3,4,5 → fifo_level=4, overflow=1, sample 5 lost; then m_ready=1 → outputs 1,2,3,4 in order and fifo_level=0. Then clr_ovf=1 for one cycle → overflow=0.
- Full with simultaneous push/pop: FIFO holds 4 entries and the 4th sample of a new group arrives in the same cycle as m_ready=1 → head popped, new average written, fifo_level stays 4, overflow stays 0.
- Reset mid-group: feed 100,100, assert rst low for 1 cycle, then feed 4,4,4,4 → single output m_data=4, and no output or contribution from the pre-reset samples.
